// File: rtl/prog_loader_if.sv
// Program BRAM port-B write bus between the serial loader and RAM8.
interface prog_loader_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_we;

    modport master (output ram_addr, output ram_data, output ram_we);
    modport slave  (input ram_addr, input ram_data, input ram_we);
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: receives a framed image over UART (8N1, LSB first)
// and writes it into the program BRAM from address 0, holding the CPU in reset
// until a complete image is in place.
// Frame: 0xA5, N (0 = 256), N data bytes [, checksum when PROG_LOADER_CSUM_EN].
// Optional macro: PROG_LOADER_CSUM_EN enables the trailing modulo-256 checksum.
module prog_loader #(
    parameter int CLK_DIV = 434,
    parameter int ADDR_W  = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    prog_loader_if.master ram,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    localparam logic [7:0]  HDR    = 8'hA5;
    localparam logic [15:0] HALF_T = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] BIT_T  = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {BIdle, BStart, BData, BStop} bit_state_t;
    typedef enum logic [2:0] {FIdle, FLen, FData, FCsum, FDone, FErr} frame_state_t;

    bit_state_t   bstate;
    frame_state_t fstate;

    logic        rx_s1, rx_s2, rx_d;
    logic [15:0] timer;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        byte_valid;
    logic        frame_err;
    logic [8:0]  len;
    logic [8:0]  cnt;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]  sum;
`endif

    // Synchroniser plus bit engine: start detect, mid-bit sampling, stop check.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_d       <= 1'b1;
            bstate     <= BIdle;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_d       <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (bstate)
                BIdle: begin
                    if (!rx_s2 && rx_d) begin
                        timer  <= HALF_T;
                        bstate <= BStart;
                    end
                end
                BStart: begin
                    if (timer == 16'd0) begin
                        // Line back high at mid-start: treat as a glitch.
                        if (rx_s2) begin
                            bstate <= BIdle;
                        end else begin
                            timer   <= BIT_T;
                            bit_cnt <= '0;
                            bstate  <= BData;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                BData: begin
                    if (timer == 16'd0) begin
                        shift <= {rx_s2, shift[7:1]};
                        timer <= BIT_T;
                        if (bit_cnt == 3'd7) begin
                            bstate <= BStop;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                BStop: begin
                    if (timer == 16'd0) begin
                        if (rx_s2) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        bstate <= BIdle;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: bstate <= BIdle;
            endcase
        end
    end

    // Frame FSM with registered RAM bus and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fstate       <= FIdle;
            len          <= '0;
            cnt          <= '0;
`ifdef PROG_LOADER_CSUM_EN
            sum          <= '0;
`endif
            ram.ram_addr <= '0;
            ram.ram_data <= '0;
            ram.ram_we   <= 1'b0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            ram.ram_we <= 1'b0;
            if (frame_err) begin
                fstate   <= FErr;
                err      <= 1'b1;
                done     <= 1'b0;
                cpu_hold <= 1'b1;
            end else if (byte_valid) begin
                case (fstate)
                    FIdle: begin
                        if (shift == HDR) fstate <= FLen;
                    end
                    FLen: begin
                        len    <= (shift == 8'd0) ? 9'd256 : {1'b0, shift};
                        cnt    <= '0;
`ifdef PROG_LOADER_CSUM_EN
                        sum    <= '0;
`endif
                        fstate <= FData;
                    end
                    FData: begin
                        ram.ram_we   <= 1'b1;
                        ram.ram_data <= shift;
                        ram.ram_addr <= ADDR_W'(cnt);
                        cnt          <= cnt + 9'd1;
`ifdef PROG_LOADER_CSUM_EN
                        sum          <= sum + shift;
                        if (cnt + 9'd1 == len) fstate <= FCsum;
`else
                        if (cnt + 9'd1 == len) begin
                            fstate   <= FDone;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end
`endif
                    end
`ifdef PROG_LOADER_CSUM_EN
                    FCsum: begin
                        if (shift == sum) begin
                            fstate   <= FDone;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            fstate   <= FErr;
                            err      <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
`endif
                    FDone: begin
                        if (shift == HDR) begin
                            fstate   <= FLen;
                            done     <= 1'b0;
                            cpu_hold <= 1'b1;
                        end
                    end
                    FErr: begin
                        if (shift == HDR) begin
                            fstate <= FLen;
                            err    <= 1'b0;
                        end
                    end
                    default: fstate <= FIdle;
                endcase
            end
        end
    end

endmodule
